// File: rtl/mem_loader_pkg.sv
// Shared types and defaults for the dmem boot/test-image loader.
// MEM_LOADER_VERIFY_EN adds the VERIFY state to the state type.
package mem_loader_pkg;

  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned CW_DEF    = 7;
  localparam int unsigned LANES     = 4;

`ifdef MEM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Packs four stream bytes big-endian into one 32-bit word.
module word_assembler
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full,
  output logic        last_byte
);

  logic [$clog2(LANES)-1:0] cnt;

  assign last_byte = shift && (cnt == '1);

  // First byte shifts all the way up to bits [31:24] after four shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      word      <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      cnt       <= '0;
      word      <= '0;
      word_full <= 1'b0;
    end else if (shift) begin
      word      <= {word[23:0], byte_in};
      cnt       <= cnt + 1'b1;
      word_full <= last_byte;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Sequential byte-stream loader driving the dmem write port.
// Define MEM_LOADER_VERIFY_EN to add the checksum readback pass.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] nwords,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [31:0]   mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd,
  output logic          busy,
  output logic          done,
  output logic          error
);

  state_t        state, state_next;
  logic [CW-1:0] idx, nwords_q;
  logic          launch, accept, last_word, last_byte, word_full;
  logic [31:0]   word;

  function automatic logic [31:0] word_addr(input logic [CW-1:0] i);
    return {{(32-CW-2){1'b0}}, i, 2'b00};
  endfunction

  assign launch    = start && (state == IDLE || state == DONE);
  assign accept    = byte_valid && byte_ready;
  assign last_word = (idx == nwords_q - CW'(1));
  assign mem_wd    = word;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (launch || state == WRITE),
    .shift     (accept),
    .byte_in   (byte_data),
    .word      (word),
    .word_full (word_full),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (launch) begin
        if (nwords == '0 || nwords > CW'(DEPTH)) state_next = DONE;
        else                                     state_next = COLLECT;
      end
      COLLECT: if (last_byte) state_next = WRITE;
`ifdef MEM_LOADER_VERIFY_EN
      WRITE:   state_next = last_word ? VERIFY : COLLECT;
      VERIFY:  if (last_word) state_next = DONE;
`else
      WRITE:   state_next = last_word ? DONE : COLLECT;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state == COLLECT);
    mem_we     = (state == WRITE) && word_full;
    busy       = (state == COLLECT) || (state == WRITE)
`ifdef MEM_LOADER_VERIFY_EN
                 || (state == VERIFY)
`endif
                 ;
    done       = (state == DONE);
  end

`ifdef MEM_LOADER_VERIFY_EN
  logic [31:0] checksum, readback;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
      readback <= '0;
    end else if (launch) begin
      checksum <= '0;
      readback <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum ^ word;
    end else if (state == VERIFY) begin
      readback <= readback ^ mem_rd;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^mem_rd;
`endif

  // idx/mem_a are rewound after the last WRITE so VERIFY can sweep from word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      nwords_q <= '0;
      mem_a    <= '0;
      error    <= 1'b0;
    end else if (launch) begin
      nwords_q <= nwords;
      idx      <= '0;
      mem_a    <= '0;
      error    <= (nwords > CW'(DEPTH));
    end else if (state == WRITE) begin
      if (!last_word) begin
        idx   <= idx + CW'(1);
        mem_a <= word_addr(idx + CW'(1));
      end
`ifdef MEM_LOADER_VERIFY_EN
      else begin
        idx   <= '0;
        mem_a <= '0;
      end
    end else if (state == VERIFY) begin
      if (last_word) begin
        error <= ((readback ^ mem_rd) != checksum);
      end else begin
        idx   <= idx + CW'(1);
        mem_a <= word_addr(idx + CW'(1));
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized self-checking bench for mem_loader with a word-level reference model.
module tb_mem_loader;

  localparam int DEPTH = 64;
  localparam int CW    = 7;
`ifdef MEM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [CW-1:0] nwords;
  logic [7:0]    byte_data;
  logic          byte_ready, mem_we, busy, done, error;
  logic [31:0]   mem_a, mem_wd, mem_rd;

  logic [31:0] mem [DEPTH];
  bit          corrupt;
  int          checks = 0;
  int          errors = 0;
  int          we_cnt;
  logic        prev_we;
  logic [7:0]  stream [$];
  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];

  always #5 clk = ~clk;

  mem_loader #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .nwords     (nwords),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // dmem model; optional fault flips a bit of word 1 as it is stored
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk)
    if (mem_we)
      mem[mem_a[7:2]] = (corrupt && mem_a == 32'h4) ? (mem_wd ^ 32'h0001_0000) : mem_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        we_cnt++;
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we actual_a=%h required=no_write", mem_a);
        end else begin
          check("wr_addr", mem_a, exp_a.pop_front());
          check("wr_data", mem_wd, exp_d.pop_front());
        end
        check("we_one_cycle", {31'b0, prev_we}, 32'd0);
        check("ready_in_write", {31'b0, byte_ready}, 32'd0);
      end
      if (!busy) check("idle_quiet", {30'b0, byte_ready, mem_we}, 32'd0);
      check("busy_done_excl", {31'b0, busy & done}, 32'd0);
      check("addr_align", {30'b0, mem_a[1:0]}, 32'd0);
    end
    prev_we = mem_we;
  end

  // mode: 0 valid always, 1 valid every other cycle, 2 random valid plus stray starts
  task automatic run_load(input int n, input int mode, input int stop_after);
    int          total, bi, k, limit, n_writes, exp_lat;
    bit          valid_n, exp_err, acc, v, fin;
    logic [31:0] words [$];
    valid_n  = (n >= 1 && n <= DEPTH);
    n_writes = valid_n ? n : 0;
    total    = 4 * n_writes;
    exp_err  = (n > DEPTH) || (VERIFY && corrupt && valid_n && n >= 2);
    exp_lat  = valid_n ? (VERIFY ? 6 * n : 5 * n) : 0;
    limit    = 40 * n_writes + 200;
    exp_a.delete();
    exp_d.delete();
    for (int w = 0; w < n_writes; w++) begin
      words.push_back({stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
      exp_a.push_back(32'(w * 4));
      exp_d.push_back(words[w]);
    end
    @(negedge clk);
    start  = 1'b1;
    nwords = CW'(n);
    we_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bi  = 0;
    k   = 0;
    fin = 1'b0;
    while (!fin) begin
      if (done) begin
        fin = 1'b1;
      end else if (k > limit) begin
        checks++;
        errors++;
        $display("FAIL timeout actual_cycles=%0d required_done_by=%0d", k, limit);
        fin = 1'b1;
      end else if (stop_after >= 0 && bi == stop_after) begin
        fin = 1'b1;
      end else begin
        case (mode)
          0:       v = (bi < total);
          1:       v = (bi < total) && (k % 2 == 0);
          default: v = (bi < total) && ($urandom_range(0, 1) == 1);
        endcase
        byte_valid = v;
        byte_data  = v ? stream[bi] : 8'($urandom);
        start      = (mode == 2) && ($urandom_range(0, 5) == 0);
        if (start) nwords = CW'($urandom);
        acc = v && byte_ready;
        @(posedge clk);
        if (acc) bi++;
        k++;
        @(negedge clk);
      end
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    if (stop_after < 0) begin
      check("error_at_done", {31'b0, error}, {31'b0, exp_err});
      check("busy_at_done", {31'b0, busy}, 32'd0);
      if (mode == 0) check("latency", k, exp_lat);
      check("we_count", we_cnt, n_writes);
      check("pending_writes", exp_a.size(), 32'd0);
      if (!corrupt)
        for (int i = 0; i < n_writes; i++) check("mem_dump", mem[i], words[i]);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; nwords = '0; byte_valid = 1'b0; byte_data = '0;
    corrupt = 1'b0; prev_we = 1'b0; we_cnt = 0;
    clear_mem();
    #1;
    check("rst_outputs", {25'b0, byte_ready, mem_we, busy, done, error, 2'b0}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    stream = {8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    run_load(2, 0, -1);
    check("lit_word0", mem[0], 32'h1234_5678);
    check("lit_word1", mem[1], 32'hABCD_EF01);

    clear_mem();
    run_load(2, 1, -1);

    run_load(0, 0, -1);
    run_load(65, 0, -1);

    stream.delete();
    for (int i = 0; i < 4 * DEPTH; i++) stream.push_back(8'(i));
    clear_mem();
    run_load(64, 0, -1);
    check("lit_last_word", mem[63], 32'hFCFD_FEFF);

    corrupt = 1'b1;
    stream.delete();
    for (int i = 0; i < 12; i++) stream.push_back(8'($urandom));
    clear_mem();
    run_load(3, 2, -1);
    corrupt = 1'b0;

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 9));
      stream.delete();
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
      clear_mem();
      run_load(n, 2, -1);
    end

    stream = {8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    clear_mem();
    run_load(2, 0, 6);
    reset = 1'b1;
    #1;
    check("midrst_outputs", {25'b0, byte_ready, mem_we, busy, done, error, 2'b0}, 32'd0);
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_mem_wd", mem_wd, 32'd0);
    check("midrst_word0_kept", mem[0], 32'h1234_5678);
    check("midrst_word1_absent", mem[1], 32'd0);
    exp_a.delete();
    exp_d.delete();
    @(negedge clk);
    reset = 1'b0;
    run_load(2, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
